// File: rtl/max_hex_display.sv
// Shows the last findMax result on a 4-digit multiplexed 7-segment display.
// Digits are scanned with a blank window at the start of each slot to hide ghosting.
module max_hex_display #(
   parameter int DIGIT_CYCLES = 50000,
   parameter int BLANK_CYCLES = 500
) (
   input  logic        mclk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        done,
   input  logic [15:0] max,
   output logic [3:0]  an,
   output logic [6:0]  seg,
   output logic        dp,
   output logic        have_res
);

   localparam int CW = (DIGIT_CYCLES > 2) ? $clog2(DIGIT_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST  = CW'(DIGIT_CYCLES - 1);
   localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);

   logic          done_q;
   logic [15:0]   shadow_q, shadow_d;
   logic          have_res_q, have_res_d;
   logic          pending_q, pending_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    idx_q, idx_d;
   logic [3:0]    an_q, an_d;
   logic [6:0]    seg_q, seg_d;
   logic          dp_q, dp_d;

   logic          done_rise;
   logic          blank;
   logic [15:0]   shifted;

   function automatic logic [6:0] hex7(input logic [3:0] n);
      logic [6:0] s;
      case (n)
         4'h0: s = 7'h40;
         4'h1: s = 7'h79;
         4'h2: s = 7'h24;
         4'h3: s = 7'h30;
         4'h4: s = 7'h19;
         4'h5: s = 7'h12;
         4'h6: s = 7'h02;
         4'h7: s = 7'h78;
         4'h8: s = 7'h00;
         4'h9: s = 7'h10;
         4'hA: s = 7'h08;
         4'hB: s = 7'h03;
         4'hC: s = 7'h46;
         4'hD: s = 7'h21;
         4'hE: s = 7'h06;
         default: s = 7'h0E;
      endcase
      return s;
   endfunction

   always_comb begin
      done_rise  = done & ~done_q;
      shadow_d   = done_rise ? max : shadow_q;
      have_res_d = have_res_q | done_rise;
      // start has priority so a new request is flagged even on a capture cycle
      if (start)          pending_d = 1'b1;
      else if (done_rise) pending_d = 1'b0;
      else                pending_d = pending_q;

      if (cnt_q == CNT_LAST) begin
         cnt_d = '0;
         idx_d = idx_q + 2'd1;
      end else begin
         cnt_d = cnt_q + 1'b1;
         idx_d = idx_q;
      end

      blank   = (cnt_q < CNT_BLANK);
      shifted = shadow_q >> {idx_q, 2'b00};
      an_d    = blank ? 4'hF : ~(4'b0001 << idx_q);
      if (blank)           seg_d = 7'h7F;
      else if (have_res_q) seg_d = hex7(shifted[3:0]);
      else                 seg_d = 7'h3F;
      dp_d    = ~(pending_q && (idx_q == 2'd0) && !blank);
   end

   always_ff @(posedge mclk or negedge rst_n) begin
      if (!rst_n) begin
         done_q     <= 1'b0;
         shadow_q   <= '0;
         have_res_q <= 1'b0;
         pending_q  <= 1'b0;
         cnt_q      <= '0;
         idx_q      <= '0;
         an_q       <= 4'hF;
         seg_q      <= 7'h7F;
         dp_q       <= 1'b1;
      end else begin
         done_q     <= done;
         shadow_q   <= shadow_d;
         have_res_q <= have_res_d;
         pending_q  <= pending_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         an_q       <= an_d;
         seg_q      <= seg_d;
         dp_q       <= dp_d;
      end
   end

   assign an       = an_q;
   assign seg      = seg_q;
   assign dp       = dp_q;
   assign have_res = have_res_q;

endmodule

// File: tb/tb_max_hex_display.sv
// Directed bench for max_hex_display with 8-cycle slots and a 1-cycle blank.
module tb_max_hex_display;

   localparam int DC = 8;
   localparam int BC = 1;

   logic        mclk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        done = 1'b0;
   logic [15:0] max = '0;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        dp;
   logic        have_res;

   int checks = 0;
   int errors = 0;
   int n = 0;  // posedges since reset release

   max_hex_display #(.DIGIT_CYCLES(DC), .BLANK_CYCLES(BC)) dut (
      .mclk(mclk), .rst_n(rst_n), .start(start), .done(done), .max(max),
      .an(an), .seg(seg), .dp(dp), .have_res(have_res)
   );

   always #5 mclk = ~mclk;

   always @(posedge mclk or negedge rst_n)
      if (!rst_n) n <= 0;
      else        n <= n + 1;

   // Output after posedge k reflects counter value k-1.
   function automatic logic [3:0] exp_an(input int k);
      if (k == 0 || ((k - 1) % DC) < BC) return 4'hF;
      return ~(4'b0001 << (((k - 1) / DC) % 4));
   endfunction

   function automatic logic [11:0] exp_out(input int k, input logic [3:0][6:0] tbl,
                                            input logic pend);
      logic [3:0] a;
      int         i;
      a = exp_an(k);
      i = (k == 0) ? 0 : ((k - 1) / DC) % 4;
      if (a == 4'hF) return {a, 7'h7F, 1'b1};
      return {a, tbl[i], ~(pend && i == 0)};
   endfunction

   task automatic test_reset();
      logic [11:0] e;
      rst_n = 1'b0;
      repeat (3) @(negedge mclk);
      checks++;
      if ({an, seg, dp, have_res} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL reset_state got an=%h seg=%h dp=%b hr=%b want F/7F/1/0", an, seg, dp, have_res);
      end
      rst_n = 1'b1;
      for (int k = 0; k < 34; k++) begin
         @(negedge mclk);
         e = exp_out(n, {4{7'h3F}}, 1'b0);
         checks++;
         if ({an, seg, dp} !== e) begin
            errors++;
            $display("FAIL reset_dash n=%0d got %h/%h/%b want %h/%h/%b", n, an, seg, dp, e[11:8], e[7:1], e[0]);
         end
      end
   endtask

   task automatic test_capture();
      logic [11:0] e;
      done = 1'b1; max = 16'h0878;
      @(negedge mclk);
      max = 16'hFFFF;  // must not be picked up while done stays high
      @(negedge mclk);
      checks++;
      if (have_res !== 1'b1) begin
         errors++;
         $display("FAIL capture_have_res got %b want 1", have_res);
      end
      for (int k = 0; k < 34; k++) begin
         @(negedge mclk);
         e = exp_out(n, {7'h40, 7'h00, 7'h78, 7'h00}, 1'b0);
         checks++;
         if ({an, seg, dp} !== e) begin
            errors++;
            $display("FAIL capture_0878 n=%0d got %h/%h/%b want %h/%h/%b", n, an, seg, dp, e[11:8], e[7:1], e[0]);
         end
      end
      done = 1'b0;
      @(negedge mclk);
   endtask

   task automatic test_pending();
      logic [11:0] e;
      start = 1'b1;
      @(negedge mclk);
      start = 1'b0;
      @(negedge mclk);
      for (int k = 0; k < 34; k++) begin
         @(negedge mclk);
         e = exp_out(n, {7'h40, 7'h00, 7'h78, 7'h00}, 1'b1);
         checks++;
         if ({an, seg, dp} !== e) begin
            errors++;
            $display("FAIL pending_dp n=%0d got %h/%h/%b want %h/%h/%b", n, an, seg, dp, e[11:8], e[7:1], e[0]);
         end
      end
      done = 1'b1; max = 16'h558E;
      @(negedge mclk);
      @(negedge mclk);
      for (int k = 0; k < 34; k++) begin
         @(negedge mclk);
         e = exp_out(n, {7'h12, 7'h12, 7'h00, 7'h06}, 1'b0);
         checks++;
         if ({an, seg, dp} !== e) begin
            errors++;
            $display("FAIL pending_clear n=%0d got %h/%h/%b want %h/%h/%b", n, an, seg, dp, e[11:8], e[7:1], e[0]);
         end
      end
      done = 1'b0;
      @(negedge mclk);
   endtask

   task automatic test_back_to_back();
      logic [11:0] e;
      start = 1'b1; done = 1'b1; max = 16'h4599;
      @(negedge mclk);
      start = 1'b0;
      @(negedge mclk);
      for (int k = 0; k < 34; k++) begin
         @(negedge mclk);
         e = exp_out(n, {7'h19, 7'h12, 7'h10, 7'h10}, 1'b1);
         checks++;
         if ({an, seg, dp} !== e) begin
            errors++;
            $display("FAIL same_cycle n=%0d got %h/%h/%b want %h/%h/%b", n, an, seg, dp, e[11:8], e[7:1], e[0]);
         end
      end
      done = 1'b0;
      @(negedge mclk);
      done = 1'b1;
      @(negedge mclk);
      @(negedge mclk);
      for (int k = 0; k < 34; k++) begin
         @(negedge mclk);
         e = exp_out(n, {7'h19, 7'h12, 7'h10, 7'h10}, 1'b0);
         checks++;
         if ({an, seg, dp} !== e) begin
            errors++;
            $display("FAIL same_cycle_clear n=%0d got %h/%h/%b want %h/%h/%b", n, an, seg, dp, e[11:8], e[7:1], e[0]);
         end
      end
      done = 1'b0;
   endtask

   task automatic test_reset_mid_scan();
      logic [11:0] e;
      bit          found = 0;
      start = 1'b1;  // leave a pending flag set so reset must clear it
      @(negedge mclk);
      start = 1'b0;
      for (int k = 0; k < 3 * DC && !found; k++) begin
         @(negedge mclk);
         if ((n % DC) == 4 && exp_an(n) != 4'hF) found = 1;
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL mid_scan_wait got no cnt=4 slot want one within %0d cycles", 3 * DC);
      end
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if ({an, seg, dp, have_res} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL mid_scan_async got an=%h seg=%h dp=%b hr=%b want F/7F/1/0", an, seg, dp, have_res);
      end
      @(negedge mclk);
      rst_n = 1'b1;
      for (int k = 0; k < 34; k++) begin
         @(negedge mclk);
         e = exp_out(n, {4{7'h3F}}, 1'b0);
         checks++;
         if ({an, seg, dp} !== e) begin
            errors++;
            $display("FAIL mid_scan_dash n=%0d got %h/%h/%b want %h/%h/%b", n, an, seg, dp, e[11:8], e[7:1], e[0]);
         end
      end
   endtask

   task automatic test_scan();
      logic [3:0] ea;
      for (int k = 0; k < 64; k++) begin
         @(negedge mclk);
         ea = exp_an(n);
         checks++;
         if (an !== ea || $countones(~an) > 1) begin
            errors++;
            $display("FAIL scan_an n=%0d got %h want %h", n, an, ea);
         end
      end
   endtask

   initial begin
      test_reset();
      test_capture();
      test_pending();
      test_back_to_back();
      test_reset_mid_scan();
      test_scan();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
